// File: rtl/sccpu_dmem_io.sv
// Data-memory stage for the single-cycle CPU.
// Holds a word-addressed RAM and a small memory-mapped I/O block made up of an
// LED register, a synchronized switch input and a programmable timer.
// Loads are combinational so that they complete within the core's cycle.
// Stores commit on the rising clock edge.
module sccpu_dmem_io #(
    parameter int ADDR_W  = 5,
    parameter int TIMER_W = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wmem,
    output logic [31:0] rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq
);

    // Word offsets inside the I/O region (addr[7:2])
    localparam logic [5:0] OFF_LED  = 6'h00;
    localparam logic [5:0] OFF_SW   = 6'h01;
    localparam logic [5:0] OFF_CNT  = 6'h02;
    localparam logic [5:0] OFF_CMP  = 6'h03;
    localparam logic [5:0] OFF_CTRL = 6'h04;

    logic [31:0]        mem [2**ADDR_W];

    logic               ram_sel;
    logic               io_sel;
    logic [ADDR_W-1:0]  ram_idx;
    logic [5:0]         io_off;

    logic               ram_we;
    logic               led_we;
    logic               cnt_we;
    logic               cmp_we;
    logic               ctrl_we;

    logic [15:0]        sw_s1;
    logic [15:0]        sw_s2;

    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] cmp;
    logic [TIMER_W-1:0] cnt_inc;
    logic               en;
    logic               auto_rl;
    logic               ie;
    logic               match;
    logic               match_evt;

    // Byte-lane bits, aliased RAM bits and (for narrow timers) upper store
    // bits carry no meaning here; folding them keeps them visibly consumed.
    logic               unused_bits;
    assign unused_bits = ^{addr, wdata};

    // Region and register decode; addr[1:0] never participates.
    assign ram_sel = (addr[31:28] == 4'h0);
    assign io_sel  = (addr[31:28] == 4'hF);
    assign ram_idx = addr[ADDR_W+1:2];
    assign io_off  = addr[7:2];

    assign ram_we  = wmem && ram_sel;
    assign led_we  = wmem && io_sel && (io_off == OFF_LED);
    assign cnt_we  = wmem && io_sel && (io_off == OFF_CNT);
    assign cmp_we  = wmem && io_sel && (io_off == OFF_CMP);
    assign ctrl_we = wmem && io_sel && (io_off == OFF_CTRL);

    // A CPU load of CNT takes priority, so a compare hit in that cycle is not
    // treated as a match event.
    assign match_evt = en && !cnt_we && (cnt == cmp);
    assign cnt_inc   = cnt + TIMER_W'(1);

    assign irq = match && ie;

    // RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_idx] <= wdata;
        end
    end

    // LED register and two-flop switch synchronizer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led   <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            if (led_we) begin
                led <= wdata[15:0];
            end
        end
    end

    // Timer compare value and control bits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cmp     <= '0;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
        end else begin
            if (cmp_we) begin
                cmp <= wdata[TIMER_W-1:0];
            end
            if (ctrl_we) begin
                en      <= wdata[0];
                auto_rl <= wdata[1];
                ie      <= wdata[2];
            end
        end
    end

    // Timer count and sticky match flag; a match in the same cycle as a
    // write-one-to-clear keeps the flag set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            match <= 1'b0;
        end else begin
            if (cnt_we) begin
                cnt <= wdata[TIMER_W-1:0];
            end else if (match_evt) begin
                cnt <= auto_rl ? '0 : cnt_inc;
            end else if (en) begin
                cnt <= cnt_inc;
            end

            if (match_evt) begin
                match <= 1'b1;
            end else if (ctrl_we && wdata[8]) begin
                match <= 1'b0;
            end
        end
    end

    // Combinational load mux; unmapped space reads as zero.
    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = mem[ram_idx];
        end else if (io_sel) begin
            case (io_off)
                OFF_LED:  rdata = {16'h0000, led};
                OFF_SW:   rdata = {16'h0000, sw_s2};
                OFF_CNT:  rdata = 32'(cnt);
                OFF_CMP:  rdata = 32'(cmp);
                OFF_CTRL: rdata = {23'd0, match, 5'd0, ie, auto_rl, en};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sccpu_dmem_io.sv
// Self-checking bench for sccpu_dmem_io: a table of RAM/I/O accesses plus
// hand-written timer, switch and reset sequences. Expected load data is queued
// when an access is driven and popped when the combinational result is sampled.
module tb_sccpu_dmem_io;

    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_SW   = 32'hF000_0004;
    localparam logic [31:0] A_CNT  = 32'hF000_0008;
    localparam logic [31:0] A_CMP  = 32'hF000_000C;
    localparam logic [31:0] A_CTRL = 32'hF000_0010;

    logic        clock;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] rdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    logic [31:0] t1_cnt [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    logic        t1_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    sccpu_dmem_io #(
        .ADDR_W (5),
        .TIMER_W(32)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .addr  (addr),
        .wdata (wdata),
        .wmem  (wmem),
        .rdata (rdata),
        .sw    (sw),
        .led   (led),
        .irq   (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one access at the falling edge; the write (if any) commits at the
    // following rising edge, while rdata shows the state before that edge.
    task automatic step(input string name, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic chk, input logic [31:0] exp);
        sb_t e;
        @(negedge clock);
        addr  = a;
        wmem  = w;
        wdata = d;
        if (chk) begin
            e.name = name;
            e.exp  = exp;
            sb_q.push_back(e);
        end
        #1;
        if (chk) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                e = sb_q.pop_front();
                check(e.name, rdata, e.exp);
            end
        end
    endtask

    task automatic add(input string name, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.name = name;
        v.a    = a;
        v.w    = w;
        v.d    = d;
        v.chk  = chk;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        addr   = '0;
        wdata  = '0;
        wmem   = 1'b0;
        sw     = '0;

        add("rst_led",      A_LED,          0, 32'h0,         1, 32'h0);
        add("rst_sw",       A_SW,           0, 32'h0,         1, 32'h0);
        add("rst_cnt",      A_CNT,          0, 32'h0,         1, 32'h0);
        add("rst_cmp",      A_CMP,          0, 32'h0,         1, 32'h0);
        add("rst_ctrl",     A_CTRL,         0, 32'h0,         1, 32'h0);
        add("ram_wr",       32'h0000_0010,  1, 32'hDEADBEEF,  0, 32'h0);
        add("ram_rd",       32'h0000_0010,  0, 32'h0,         1, 32'hDEADBEEF);
        add("ram_rd_b3",    32'h0000_0013,  0, 32'h0,         1, 32'hDEADBEEF);
        add("ram_alias",    32'h0000_0090,  0, 32'h0,         1, 32'hDEADBEEF);
        add("ram_wr_old",   32'h0000_0010,  1, 32'h1234_5678, 1, 32'hDEADBEEF);
        add("ram_rd_new",   32'h0000_0010,  0, 32'h0,         1, 32'h1234_5678);
        add("ram_wr2",      32'h0000_0014,  1, 32'hCAFE_F00D, 0, 32'h0);
        add("ram_alias_hi", 32'h0FFF_FF14,  0, 32'h0,         1, 32'hCAFE_F00D);
        add("hole_wr",      32'h8000_0010,  1, 32'hFFFF_FFFF, 1, 32'h0);
        add("hole_rd",      32'h8000_0000,  0, 32'h0,         1, 32'h0);
        add("hole_nowr",    32'h0000_0010,  0, 32'h0,         1, 32'h1234_5678);
        add("led_wr",       A_LED,          1, 32'h0001_A5A5, 0, 32'h0);
        add("led_rd",       A_LED,          0, 32'h0,         1, 32'h0000_A5A5);
        add("led_rd_b3",    32'hF000_0003,  0, 32'h0,         1, 32'h0000_A5A5);
        add("unmap_wr",     32'hF000_0020,  1, 32'hFFFF_FFFF, 1, 32'h0);
        add("unmap_rd",     32'hF000_0020,  0, 32'h0,         1, 32'h0);
        add("led_keep",     A_LED,          0, 32'h0,         1, 32'h0000_A5A5);
        add("cnt_keep",     A_CNT,          0, 32'h0,         1, 32'h0);
        add("cmp_keep",     A_CMP,          0, 32'h0,         1, 32'h0);
        add("ctrl_keep",    A_CTRL,         0, 32'h0,         1, 32'h0);
        add("sw_wr",        A_SW,           1, 32'h0000_FFFF, 1, 32'h0);
        add("sw_ro",        A_SW,           0, 32'h0,         1, 32'h0);
        add("cmp_wr",       A_CMP,          1, 32'h0000_0077, 0, 32'h0);
        add("cmp_rd",       A_CMP,          0, 32'h0,         1, 32'h0000_0077);

        // Reset state, observed while reset is held
        repeat (2) @(negedge clock);
        #1;
        check("rst_led_pin", 32'(led), 32'h0);
        check("rst_irq_pin", 32'(irq), 32'h0);
        @(negedge clock);
        resetn = 1'b1;

        // Table-driven RAM and I/O decode
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].chk, vecs[i].exp);
        end
        check("led_pin", 32'(led), 32'h0000_A5A5);

        // Reset asserted mid-cycle with an LED write in flight
        @(negedge clock);
        addr  = A_LED;
        wdata = 32'h0000_5555;
        wmem  = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_led_now", 32'(led), 32'h0);
        check("midrst_cmp_rd", rdata, 32'h0);
        @(negedge clock);
        wmem   = 1'b0;
        resetn = 1'b1;
        step("midrst_led_rd", A_LED, 0, 32'h0, 1, 32'h0);
        step("midrst_cmp",    A_CMP, 0, 32'h0, 1, 32'h0);
        check("midrst_led_pin", 32'(led), 32'h0);

        // Switch synchronizer latency
        @(negedge clock);
        sw   = 16'h1234;
        addr = A_SW;
        #1;
        check("sw_0edge", rdata, 32'h0);
        step("sw_1edge", A_SW, 0, 32'h0, 1, 32'h0);
        step("sw_2edge", A_SW, 0, 32'h0, 1, 32'h0000_1234);

        // Timer with auto-reload and interrupt enabled
        step("t1_cmp",  A_CMP,  1, 32'd3, 0, 32'h0);
        step("t1_cnt",  A_CNT,  1, 32'd0, 0, 32'h0);
        step("t1_ctrl", A_CTRL, 1, 32'h7, 0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("t1_cnt%0d", i), A_CNT, 0, 32'h0, 1, t1_cnt[i]);
            check($sformatf("t1_irq%0d", i), 32'(irq), 32'(t1_irq[i]));
        end
        step("t1_ctrl_m", A_CTRL, 0, 32'h0, 1, 32'h0000_0107);
        step("t1_cnt3",   A_CNT,  0, 32'h0, 1, 32'd3);
        check("t1_irq_held", 32'(irq), 32'h1);
        step("t1_w1c",      A_CTRL, 1, 32'h0000_0100, 1, 32'h0000_0107);
        step("t1_ctrl_clr", A_CTRL, 0, 32'h0, 1, 32'h0);
        check("t1_irq_clr", 32'(irq), 32'h0);
        step("t1_frz_a", A_CNT, 0, 32'h0, 1, 32'd1);
        step("t1_frz_b", A_CNT, 0, 32'h0, 1, 32'd1);

        // Timer without auto-reload: pass-through, wrap, set-wins, CPU override
        step("t2_cmp",  A_CMP,  1, 32'd2, 0, 32'h0);
        step("t2_cnt",  A_CNT,  1, 32'd0, 0, 32'h0);
        step("t2_ctrl", A_CTRL, 1, 32'h1, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t2_cnt%0d", i), A_CNT, 0, 32'h0, 1, 32'(i));
        end
        step("t2_ctrl_m",   A_CTRL, 0, 32'h0,         1, 32'h0000_0101);
        check("t2_irq_ie0", 32'(irq), 32'h0);
        step("t2_w1c",      A_CTRL, 1, 32'h0000_0101, 1, 32'h0000_0101);
        step("t2_ctrl_c",   A_CTRL, 0, 32'h0,         1, 32'h0000_0001);
        step("t2_ld_max",   A_CNT,  1, 32'hFFFF_FFFF, 1, 32'd7);
        step("t2_max",      A_CNT,  0, 32'h0,         1, 32'hFFFF_FFFF);
        step("t2_wrap",     A_CNT,  0, 32'h0,         1, 32'h0);
        step("t2_nomatch",  A_CTRL, 0, 32'h0,         1, 32'h0000_0001);
        step("t2_w1c_hit",  A_CTRL, 1, 32'h0000_0101, 1, 32'h0000_0001);
        step("t2_setwins",  A_CTRL, 0, 32'h0,         1, 32'h0000_0101);
        step("t2_ld2",      A_CNT,  1, 32'd2,         1, 32'd4);
        step("t2_ovr",      A_CNT,  1, 32'd5,         1, 32'd2);
        step("t2_ovr_rd",   A_CNT,  0, 32'h0,         1, 32'd5);
        step("t2_match_kept", A_CTRL, 0, 32'h0,       1, 32'h0000_0101);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
